// File: rtl/spi_instr_sequencer.sv
// Instruction-driven SPI transmitter for a display link: runs a program held in a local
// memory and shifts CMD/DATA payload bytes out MSB first on serial-clock falling edges.
module spi_instr_sequencer #(
    parameter int unsigned MEM_BITS   = 10,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclkPosEdge,
    input  logic                  sclkNegEdge,
    input  logic                  start,
    input  logic                  writeEnable,
    input  logic [ADDR_WIDTH-1:0] writeAddr,
    input  logic [MEM_BITS-1:0]   dataIn,
    output logic                  cs,
    output logic                  dc,
    output logic                  mosi,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;
    localparam int unsigned OP_BITS  = 2;
    localparam int unsigned CNT_BITS = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_SHIFT  = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

    typedef enum logic [OP_BITS-1:0] {
        OP_CMD  = 2'b00,
        OP_DATA = 2'b01,
        OP_NOP  = 2'b10,
        OP_END  = 2'b11
    } opcode_e;

    logic [MEM_BITS-1:0]   mem_q [DEPTH];
    logic [MEM_BITS-1:0]   rdata_q;

    state_e                state_q,  state_d;
    logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
    logic                  cs_q,     cs_d;
    logic                  dc_q,     dc_d;
    logic                  mosi_q,   mosi_d;
    logic                  busy_q,   busy_d;
    logic                  done_q,   done_d;
    logic [DATA_BITS-1:0]  shreg_q,  shreg_d;
    logic [CNT_BITS-1:0]   bitcnt_q, bitcnt_d;

    logic [OP_BITS-1:0]    op_c;
    logic [DATA_BITS-1:0]  payload_c;

    // Program memory: contents survive reset; read data lags addr by one cycle.
    always_ff @(posedge clk) begin
        if (writeEnable) begin
            mem_q[writeAddr] <= dataIn;
        end
        rdata_q <= mem_q[addr_q];
    end

    assign op_c      = rdata_q[MEM_BITS-1 -: OP_BITS];
    assign payload_c = rdata_q[DATA_BITS-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            cs_q     <= 1'b1;
            dc_q     <= 1'b0;
            mosi_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            shreg_q  <= '0;
            bitcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cs_q     <= cs_d;
            dc_q     <= dc_d;
            mosi_q   <= mosi_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cs_d     = cs_q;
        dc_d     = dc_q;
        mosi_d   = mosi_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;

        case (state_q)
            ST_IDLE: begin
                cs_d = 1'b1;
                if (start) begin
                    addr_d  = '0;
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                state_d = ST_DECODE;
            end

            ST_DECODE: begin
                case (op_c)
                    OP_END: begin
                        cs_d    = 1'b1;
                        state_d = ST_HALT;
                    end
                    OP_NOP: begin
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                        state_d = ST_FETCH;
                    end
                    default: begin
                        shreg_d  = payload_c;
                        dc_d     = op_c[0];
                        cs_d     = 1'b0;
                        bitcnt_d = '0;
                        state_d  = ST_SHIFT;
                    end
                endcase
            end

            // Falling edge drives the next bit; the rising edge after the last bit ends the byte.
            ST_SHIFT: begin
                if (sclkNegEdge && (bitcnt_q < CNT_BITS'(DATA_BITS))) begin
                    mosi_d   = shreg_q[DATA_BITS-1];
                    shreg_d  = {shreg_q[DATA_BITS-2:0], 1'b0};
                    bitcnt_d = bitcnt_q + CNT_BITS'(1);
                end
                if (sclkPosEdge && (bitcnt_d == CNT_BITS'(DATA_BITS))) begin
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    state_d = ST_FETCH;
                end
            end

            ST_HALT: begin
                cs_d = 1'b1;
                if (start) begin
                    addr_d  = '0;
                    state_d = ST_FETCH;
                end
            end

            default: begin
                cs_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_FETCH) || (state_d == ST_DECODE) || (state_d == ST_SHIFT);
        done_d = (state_d == ST_HALT);
    end

    assign cs   = cs_q;
    assign dc   = dc_q;
    assign mosi = mosi_q;
    assign addr = addr_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_spi_instr_sequencer.sv
// Bench for spi_instr_sequencer: a program-level reference model queues expected bytes,
// an SPI-slave-style monitor reassembles bytes from the pins and scores them.
module tb_spi_instr_sequencer;

    localparam int unsigned MEM_BITS   = 10;
    localparam int unsigned ADDR_WIDTH = 10;
    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned DEPTH      = 2 ** ADDR_WIDTH;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  sclkPosEdge = 1'b0;
    logic                  sclkNegEdge = 1'b0;
    logic                  start = 1'b0;
    logic                  writeEnable = 1'b0;
    logic [ADDR_WIDTH-1:0] writeAddr = '0;
    logic [MEM_BITS-1:0]   dataIn = '0;
    logic                  cs, dc, mosi, busy, done;
    logic [ADDR_WIDTH-1:0] addr;

    int checks = 0;
    int errors = 0;
    int sclk_half = 4;
    int sclk_cnt = 0;

    logic [MEM_BITS-1:0] model_mem [DEPTH];
    logic [8:0]          exp_q [$];

    spi_instr_sequencer #(
        .MEM_BITS   (MEM_BITS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_BITS  (DATA_BITS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sclkPosEdge (sclkPosEdge),
        .sclkNegEdge (sclkNegEdge),
        .start       (start),
        .writeEnable (writeEnable),
        .writeAddr   (writeAddr),
        .dataIn      (dataIn),
        .cs          (cs),
        .dc          (dc),
        .mosi        (mosi),
        .addr        (addr),
        .busy        (busy),
        .done        (done)
    );

    initial forever #5 clk = ~clk;

    // Free-running serial clock strobes; half period of at least 3 clk cycles.
    initial forever begin
        @(posedge clk); #1;
        sclk_cnt    = (sclk_cnt + 1) % (2 * sclk_half);
        sclkNegEdge = (sclk_cnt == 0);
        sclkPosEdge = (sclk_cnt == sclk_half);
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic write_mem(input int a, input logic [MEM_BITS-1:0] d);
        tick();
        writeEnable = 1'b1;
        writeAddr   = ADDR_WIDTH'(a);
        dataIn      = d;
        model_mem[a] = d;
        tick();
        writeEnable = 1'b0;
    endtask

    // Walk the program from address 0 and queue each byte it should emit.
    task automatic model_run(output int final_addr);
        int a;
        logic [MEM_BITS-1:0] w;
        a = 0;
        final_addr = -1;
        for (int s = 0; s < 4 * DEPTH; s++) begin
            w = model_mem[a];
            if (w[9:8] == 2'b11) begin
                final_addr = a;
                break;
            end
            if (w[9] == 1'b0) exp_q.push_back({w[8], w[7:0]});
            a = (a + 1) % DEPTH;
        end
    endtask

    task automatic start_run(output int exp_addr);
        model_run(exp_addr);
        tick(); start = 1'b1;
        tick(); start = 1'b0;
        @(negedge clk);
        check("busy_after_start", 32'(busy), 32'(1));
    endtask

    task automatic wait_done(input string name, input int budget, input int restart_at,
                             output bit cs_low, output int cyc);
        cyc = 0;
        cs_low = 0;
        while (done !== 1'b1 && cyc < budget) begin
            if (cs === 1'b0) cs_low = 1;
            if (restart_at >= 0 && cyc == restart_at) begin
                tick(); start = 1'b1;
                tick(); start = 1'b0;
                cyc += 2;
            end
            @(negedge clk);
            cyc++;
        end
        check({name, "_done_reached"}, 32'(done), 32'(1));
    endtask

    task automatic finish_checks(input string name, input int exp_addr);
        repeat (2) @(negedge clk);
        check({name, "_addr"}, 32'(addr), 32'(exp_addr));
        check({name, "_cs"}, 32'(cs), 32'(1));
        check({name, "_busy"}, 32'(busy), 32'(0));
        check({name, "_done"}, 32'(done), 32'(1));
        check({name, "_bytes_outstanding"}, 32'(exp_q.size()), 32'(0));
        exp_q.delete();
    endtask

    // Slave-side monitor: shifts mosi on each rising strobe while cs is low; a byte ends
    // where the program counter advances right after such a strobe.
    initial begin
        logic [7:0]            hist;
        int                    negcnt;
        bit                    pend;
        logic                  pend_dc;
        logic [8:0]            e;
        logic [ADDR_WIDTH-1:0] p_addr;
        logic                  p_mosi, p_cs, p_neg, p_reset;
        hist = '0; negcnt = 0; pend = 0; pend_dc = 1'b0;
        p_addr = '0; p_mosi = 1'b0; p_cs = 1'b1; p_neg = 1'b0; p_reset = 1'b1;
        forever begin
            @(negedge clk);
            if (reset) begin
                hist = '0;
                negcnt = 0;
                pend = 0;
            end else begin
                if (pend && addr != p_addr) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got dc=%0b byte=0x%02h expected none", pend_dc, hist);
                    end else begin
                        e = exp_q.pop_front();
                        check("spi_byte_dc_data", 32'({pend_dc, hist}), 32'(e));
                    end
                end
                if (addr != p_addr || start) negcnt = 0;
                if (!p_reset && mosi != p_mosi) check("mosi_change_follows_negedge", 32'(p_neg), 32'(1));
                if (!p_reset && p_cs == 1'b0 && cs == 1'b1) check("cs_rises_only_into_halt", 32'(done), 32'(1));
                pend = 0;
                if (sclkNegEdge && !cs) negcnt++;
                if (sclkPosEdge && !cs) begin
                    hist    = {hist[6:0], mosi};
                    pend    = (negcnt > 0);
                    pend_dc = dc;
                end
            end
            p_addr = addr; p_mosi = mosi; p_cs = cs; p_neg = sclkNegEdge; p_reset = reset;
        end
    end

    initial begin
        int   ea, cyc, n, len, k;
        bit   low;
        logic mosi0;
        logic [1:0] op;

        for (int i = 0; i < DEPTH; i++) model_mem[i] = 10'h300;

        // Reset state
        repeat (2) tick();
        @(negedge clk);
        check("rst_cs", 32'(cs), 32'(1));
        check("rst_dc", 32'(dc), 32'(0));
        check("rst_mosi", 32'(mosi), 32'(0));
        check("rst_addr", 32'(addr), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        tick(); reset = 1'b0;

        // Single command byte 0xA5
        write_mem(0, 10'h0A5);
        write_mem(1, 10'h300);
        start_run(ea);
        wait_done("cmd_a5", 3000, -1, low, cyc);
        check("cmd_a5_cs_fell", 32'(low), 32'(1));
        finish_checks("cmd_a5", ea);

        // Data then command, cs held low across both bytes
        write_mem(0, 10'h13C);
        write_mem(1, 10'h0FF);
        write_mem(2, 10'h300);
        start_run(ea);
        wait_done("two_bytes", 3000, -1, low, cyc);
        finish_checks("two_bytes", ea);

        // NOP then END: no transfer at all
        write_mem(0, 10'h200);
        write_mem(1, 10'h300);
        mosi0 = mosi;
        start_run(ea);
        wait_done("nop", 3000, -1, low, cyc);
        check("nop_cycles_to_done", 32'(cyc), 32'(4));
        check("nop_cs_never_low", 32'(low), 32'(0));
        check("nop_mosi_held", 32'(mosi), 32'(mosi0));
        finish_checks("nop", ea);

        // Reset while the fourth bit is on the wire, then rerun from intact memory
        write_mem(0, 10'h0C3);
        write_mem(1, 10'h1F0);
        write_mem(2, 10'h300);
        start_run(ea);
        n = 0;
        for (int c = 0; c < 1000 && n < 4; c++) begin
            if (cs === 1'b0 && sclkNegEdge) n++;
            if (n < 4) @(negedge clk);
        end
        check("midbyte_reached", 32'(n), 32'(4));
        tick(); reset = 1'b1;
        tick(); reset = 1'b0;
        @(negedge clk);
        check("midbyte_rst_cs", 32'(cs), 32'(1));
        check("midbyte_rst_addr", 32'(addr), 32'(0));
        check("midbyte_rst_busy", 32'(busy), 32'(0));
        check("midbyte_rst_done", 32'(done), 32'(0));
        exp_q.delete();
        start_run(ea);
        wait_done("rerun_after_rst", 3000, -1, low, cyc);
        finish_checks("rerun_after_rst", ea);

        // start while busy is ignored; start from HALT reruns identically
        write_mem(0, 10'h1AA);
        write_mem(1, 10'h055);
        write_mem(2, 10'h300);
        start_run(ea);
        wait_done("busy_start", 3000, 20, low, cyc);
        finish_checks("busy_start", ea);
        start_run(ea);
        wait_done("halt_rerun", 3000, -1, low, cyc);
        finish_checks("halt_rerun", ea);

        // Randomised programs under varying serial clock rates
        for (int r = 0; r < 10; r++) begin
            sclk_half = int'($urandom_range(3, 5));
            len = int'($urandom_range(1, 8));
            for (int i = 0; i < len; i++) begin
                k  = int'($urandom_range(0, 9));
                op = (k < 4) ? 2'b00 : ((k < 8) ? 2'b01 : 2'b10);
                write_mem(i, {op, 8'($urandom)});
            end
            write_mem(len, 10'h300);
            start_run(ea);
            wait_done("random", 5000, -1, low, cyc);
            finish_checks("random", ea);
        end

        // Address wrap: NOPs to the top, a command at the last word, END poked into word 0 mid-run
        sclk_half = 4;
        for (int a = 0; a < DEPTH; a++) write_mem(a, 10'h200);
        write_mem(DEPTH - 1, 10'h081);
        exp_q.push_back(9'h081);
        tick(); start = 1'b1;
        tick(); start = 1'b0;
        repeat (10) @(negedge clk);
        write_mem(0, 10'h300);
        wait_done("wrap", 8000, -1, low, cyc);
        finish_checks("wrap", 0);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
